// File: rtl/riscv_state_dump_if.sv
// Bus bundle for riscv_state_dump: register-file and data-memory read ports plus
// the valid/ready result stream. The master side is the dump engine.
interface riscv_state_dump_if #(
   parameter int WIDTH = 32
);
   logic             reg_re;
   logic [4:0]       reg_addr;
   logic [WIDTH-1:0] reg_rdata;
   logic             mem_re;
   logic [9:0]       mem_addr;
   logic [WIDTH-1:0] mem_rdata;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;

   modport master (
      output reg_re, reg_addr,
      input  reg_rdata,
      output mem_re, mem_addr,
      input  mem_rdata,
      output out_valid, out_data, out_last,
      input  out_ready
   );

   modport slave (
      input  reg_re, reg_addr,
      output reg_rdata,
      input  mem_re, mem_addr,
      output mem_rdata,
      input  out_valid, out_data, out_last,
      output out_ready
   );
endinterface

// File: rtl/riscv_state_dump.sv
// End-of-run state dump: streams x0..x(NREGS-1) then DMem[0..DMEM_DEPTH-1] through a
// 2-entry credit-managed FIFO. Define DUMP_HEADER_EN to prepend a {16'hDB60, count} header.
module riscv_state_dump #(
   parameter int NREGS      = 32,
   parameter int DMEM_DEPTH = 1024,
   parameter int WIDTH      = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   riscv_state_dump_if.master bus
);

`ifdef DUMP_HEADER_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   localparam logic [15:0]      WORD_COUNT = 16'(NREGS + DMEM_DEPTH);
   localparam logic [WIDTH-1:0] HDR_WORD   = WIDTH'({16'hDB60, WORD_COUNT});

   typedef enum logic [2:0] {IDLE, HDR, REGS, MEM, DRAIN, DONE} state_t;
   typedef enum logic [1:0] {SRC_HDR, SRC_REG, SRC_MEM} src_t;

   state_t         state, state_nx;
   logic [15:0]    idx, idx_nx;
   logic           inflight, inflight_last;
   src_t           inflight_src;
   logic [WIDTH:0] fifo [2];
   logic           wr_ptr, rd_ptr;
   logic [1:0]     count;

   logic           issue_ok, issue, issue_last;
   src_t           issue_src;
   logic           pop, fifo_push, fifo_pop, head_valid;
   logic [WIDTH:0] ret_word, head_word;

   // Returning read data bypasses an empty FIFO so a word is visible the cycle it arrives.
   always_comb begin
      ret_word = '0;
      case (inflight_src)
         SRC_HDR: ret_word = {1'b0, HDR_WORD};
         SRC_REG: ret_word = {1'b0, bus.reg_rdata};
         SRC_MEM: ret_word = {inflight_last, bus.mem_rdata};
         default: ret_word = '0;
      endcase
   end

   assign head_valid = (count != 2'd0) || inflight;
   assign head_word  = (count != 2'd0) ? fifo[rd_ptr] : ret_word;
   assign pop        = head_valid && bus.out_ready;
   assign fifo_pop   = pop && (count != 2'd0);
   assign fifo_push  = inflight && !(pop && (count == 2'd0));
   assign issue_ok   = ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

   assign bus.out_valid = head_valid;
   assign bus.out_data  = head_valid ? head_word[WIDTH-1:0] : '0;
   assign bus.out_last  = head_valid ? head_word[WIDTH] : 1'b0;
   assign busy          = (state != IDLE) && (state != DONE);
   assign done          = (state == DONE);

   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      issue        = 1'b0;
      issue_src    = SRC_REG;
      issue_last   = 1'b0;
      bus.reg_re   = 1'b0;
      bus.reg_addr = '0;
      bus.mem_re   = 1'b0;
      bus.mem_addr = '0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = HDR_EN ? HDR : REGS;
               idx_nx   = '0;
            end
         end
         HDR: begin
            if (issue_ok) begin
               issue     = 1'b1;
               issue_src = SRC_HDR;
               state_nx  = REGS;
            end
         end
         REGS: begin
            if (issue_ok) begin
               issue        = 1'b1;
               issue_src    = SRC_REG;
               bus.reg_re   = 1'b1;
               bus.reg_addr = idx[4:0];
               if (idx == 16'(NREGS - 1)) begin
                  idx_nx   = '0;
                  state_nx = MEM;
               end else begin
                  idx_nx = idx + 16'd1;
               end
            end
         end
         MEM: begin
            if (issue_ok) begin
               issue        = 1'b1;
               issue_src    = SRC_MEM;
               bus.mem_re   = 1'b1;
               bus.mem_addr = idx[9:0];
               if (idx == 16'(DMEM_DEPTH - 1)) begin
                  issue_last = 1'b1;
                  idx_nx     = '0;
                  state_nx   = DRAIN;
               end else begin
                  idx_nx = idx + 16'd1;
               end
            end
         end
         DRAIN: begin
            // Leave as soon as the final pop empties the buffer, so done follows immediately.
            if (({1'b0, count} + {2'b0, inflight}) == {2'b0, pop})
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         inflight_src  <= SRC_REG;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         count         <= '0;
         fifo[0]       <= '0;
         fifo[1]       <= '0;
      end else begin
         state    <= state_nx;
         idx      <= idx_nx;
         inflight <= issue;
         if (issue) begin
            inflight_src  <= issue_src;
            inflight_last <= issue_last;
         end
         if (fifo_push) begin
            fifo[wr_ptr] <= ret_word;
            wr_ptr       <= ~wr_ptr;
         end
         if (fifo_pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, fifo_push} - {1'b0, fifo_pop};
      end
   end

endmodule

// File: tb/tb_riscv_state_dump.sv
// Self-checking bench for riscv_state_dump: table of dump scenarios plus hand-written
// reset-state and reset-mid-dump sequences; a negedge monitor checks every stream word.
module tb_riscv_state_dump;
   localparam int NREGS      = 32;
   localparam int DMEM_DEPTH = 1024;
   localparam int WIDTH      = 32;
`ifdef DUMP_HEADER_EN
   localparam int H = 1;
`else
   localparam int H = 0;
`endif
   localparam int READS = NREGS + DMEM_DEPTH;
   localparam int TOTAL = READS + H;

   logic clk = 1'b0;
   logic rst, start, busy, done;

   riscv_state_dump_if #(.WIDTH(WIDTH)) bus ();

   riscv_state_dump #(.NREGS(NREGS), .DMEM_DEPTH(DMEM_DEPTH), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Regs[i] = 3*i, DMem[i] = ~i, one-cycle read latency
   always @(posedge clk) begin
      if (bus.reg_re) bus.reg_rdata <= 32'(3 * int'(bus.reg_addr));
      if (bus.mem_re) bus.mem_rdata <= ~{22'd0, bus.mem_addr};
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_word(input int k);
      int j;
      if (H == 1 && k == 0) return 32'hDB60_0420;
      j = k - H;
      if (j < NREGS) return 32'(3 * j);
      return ~32'(j - NREGS);
   endfunction

   bit          mon_en = 1'b0;
   int          start_cyc, rd_idx, issued, popped, widx, last_rel, done_rel;
   bit          done_seen, stall_prev;
   logic [31:0] prev_data;
   logic        prev_last;

   task automatic mon_start();
      rd_idx     = 0;
      issued     = H;
      popped     = 0;
      widx       = 0;
      last_rel   = -1;
      done_rel   = -1;
      done_seen  = 1'b0;
      stall_prev = 1'b0;
      start_cyc  = cyc;
      mon_en     = 1'b1;
   endtask

   always @(negedge clk) begin : monitor
      int rel;
      if (mon_en && !rst) begin
         rel = cyc - start_cyc;
         chk("re_exclusive", 32'(bus.reg_re & bus.mem_re), 32'd0);
         if (bus.reg_re) begin
            chk("reg_addr", 32'(bus.reg_addr), 32'(rd_idx));
            chk("reg_phase", 32'(rd_idx < NREGS), 32'd1);
            rd_idx++;
            issued++;
         end
         if (bus.mem_re) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(rd_idx - NREGS));
            chk("mem_phase", 32'(rd_idx >= NREGS && rd_idx < READS), 32'd1);
            rd_idx++;
            issued++;
         end
         if (stall_prev) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_data", bus.out_data, prev_data);
            chk("stall_last", 32'(bus.out_last), 32'(prev_last));
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("word", bus.out_data, exp_word(widx));
            chk("last_flag", 32'(bus.out_last), 32'(widx == TOTAL - 1));
            widx++;
            popped++;
            last_rel = rel;
         end
         chk("credit", 32'((issued - popped) <= 2), 32'd1);
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
         if (done && !done_seen) begin
            done_seen = 1'b1;
            done_rel  = rel;
            chk("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   // mode 0: ready high, 1: ready toggles 1,0,1,0..., 2: ready low through cycle 'stall'
   task automatic run_dump(input string name, input int mode, input int stall, input bit extra,
                           input int exp_last, input int exp_done);
      int rel;
      @(posedge clk); #1;
      start         = 1'b1;
      bus.out_ready = 1'b0;
      mon_start();
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, ":busy_c1"}, 32'(busy), 32'd1);
      chk({name, ":reg_re_c1"}, 32'(bus.reg_re), 32'(H == 0));
      chk({name, ":reg_addr_c1"}, 32'(bus.reg_addr), 32'd0);
      rel = 1;
      while (!done_seen && rel < 4000) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = rel[0];
            default: bus.out_ready = (rel > stall);
         endcase
         start = extra && (rel == 10 || rel == 600);
         if (mode == 2 && rel == stall) begin
            chk({name, ":stall_reads"}, 32'(rd_idx), 32'(2 - H));
            chk({name, ":stall_head_valid"}, 32'(bus.out_valid), 32'd1);
            chk({name, ":stall_head_data"}, bus.out_data, exp_word(0));
         end
         @(posedge clk); #1;
         rel++;
      end
      start = 1'b0;
      chk({name, ":done_seen"}, 32'(done_seen), 32'd1);
      chk({name, ":word_count"}, 32'(widx), 32'(TOTAL));
      chk({name, ":read_count"}, 32'(rd_idx), 32'(READS));
      if (exp_last >= 0) chk({name, ":last_hs_cycle"}, 32'(last_rel), 32'(exp_last));
      if (exp_done >= 0) chk({name, ":done_cycle"}, 32'(done_rel), 32'(exp_done));
      chk({name, ":done_one_cycle"}, 32'(done), 32'd0);
      chk({name, ":busy_after"}, 32'(busy), 32'd0);
      mon_en        = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   typedef struct {
      string name;
      int    mode;
      int    stall;
      bit    extra;
      int    exp_last;
      int    exp_done;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int n;
      vecs[0] = '{"ready_high",    0, 0,   1'b0, 1057 + H, 1058 + H};
      vecs[1] = '{"ready_toggle",  1, 0,   1'b0, -1,       -1};
      vecs[2] = '{"stall_100",     2, 100, 1'b0, 1156 + H, 1157 + H};
      vecs[3] = '{"start_ignored", 0, 0,   1'b1, 1057 + H, 1058 + H};

      rst           = 1'b1;
      start         = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", 32'({busy, done, bus.reg_re, bus.reg_addr, bus.mem_re, bus.mem_addr,
                             bus.out_valid, bus.out_last}), 32'd0);
      chk("reset_data", bus.out_data, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++)
         run_dump(vecs[i].name, vecs[i].mode, vecs[i].stall, vecs[i].extra,
                  vecs[i].exp_last, vecs[i].exp_done);

      // reset right after the 500th handshake
      @(posedge clk); #1;
      start         = 1'b1;
      bus.out_ready = 1'b1;
      mon_start();
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (popped < 500 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("midrst_reached_500", 32'(popped), 32'd500);
      chk("midrst_busy_before", 32'(busy), 32'd1);
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      chk("midrst_ctrl", 32'({busy, done, bus.reg_re, bus.reg_addr, bus.mem_re, bus.mem_addr,
                              bus.out_valid, bus.out_last}), 32'd0);
      chk("midrst_data", bus.out_data, 32'd0);
      @(posedge clk); #1;
      rst           = 1'b0;
      bus.out_ready = 1'b0;

      run_dump("restart", 0, 0, 1'b0, 1057 + H, 1058 + H);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
